// File: rtl/seg_display_ctrl_pkg.sv
// Shared types and constants for the 7-segment display scheduler.
// Used by seg_display_ctrl and seg_prescaler via import seg_ctrl_pkg::*.
package seg_ctrl_pkg;

  // Display ownership states.
  typedef enum logic [1:0] {
    S_OFF = 2'd0,
    S_PRI = 2'd1,
    S_OVL = 2'd2
  } state_t;

  // Encodings presented on src_sel.
  localparam logic [1:0] SRC_NONE = 2'b00;
  localparam logic [1:0] SRC_PRI  = 2'b01;
  localparam logic [1:0] SRC_OVL  = 2'b10;

  // Nibble code the driver renders as an unlit digit.
  localparam logic [3:0] BLANK_NIBBLE = 4'hF;

  // Leading-zero blanking: from digit 3 down, zero nibbles become blank
  // until the first non-zero nibble. Digit 0 is always shown so that a
  // value of zero still displays a single "0".
  function automatic logic [15:0] lzb_word(input logic [15:0] w);
    logic [15:0] r;
    logic        leading;
    r       = w;
    leading = 1'b1;
    for (int i = 3; i >= 1; i--) begin
      if (leading && (w[i*4 +: 4] == 4'h0)) begin
        r[i*4 +: 4] = BLANK_NIBBLE;
      end else begin
        leading = 1'b0;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/seg_prescaler.sv
// Free-running refresh prescaler: one-cycle tick every PRESCALE clocks.
// The tick is registered and is high exactly in the cycle where the count
// sits at PRESCALE-1. Independent of display state and blanking.
module seg_prescaler
  import seg_ctrl_pkg::*;
#(
  parameter int PRESCALE = 50000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int CNT_W = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PRESCALE - 1);
  // The tick flop is loaded one cycle early so it lines up with CNT_LAST.
  localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(PRESCALE - 2);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick_q, tick_d;

  // Next count with wrap, and early decode of the terminal count.
  always_comb begin
    cnt_d  = cnt_q;
    tick_d = 1'b0;
    if (cnt_q == CNT_LAST) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    if (cnt_q == CNT_PRE) begin
      tick_d = 1'b1;
    end else begin
      tick_d = 1'b0;
    end
  end

  // Counter and tick registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/seg_display_ctrl.sv
// Display scheduler and source arbiter in front of a 4-digit 7-segment
// driver. Arbitrates between a steady primary source and a timed overlay,
// generates the refresh tick and presents a registered BCD word.
// Optional build macro: SEG_LZB_EN enables leading-zero blanking on bcd_out.
module seg_display_ctrl
  import seg_ctrl_pkg::*;
#(
  parameter int PRESCALE   = 50000,
  parameter int HOLD_TICKS = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] pri_bcd,
  input  logic        pri_valid,
  input  logic [15:0] ovl_bcd,
  input  logic        ovl_req,
  output logic        ovl_ack,
  output logic        ovl_busy,
  input  logic        blank,
  output logic        refresh_tick,
  output logic        disp_en,
  output logic [15:0] bcd_out,
  output logic [1:0]  src_sel
);

  localparam int HOLD_W = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_TICKS - 1);

  // Word formatting applied in the output register stage.
  function automatic logic [15:0] fmt_word(input logic [15:0] w);
`ifdef SEG_LZB_EN
    return lzb_word(w);
`else
    return w;
`endif
  endfunction

  logic              tick;
  state_t            state_q, state_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [15:0]       bcd_q, bcd_d;
  logic [1:0]        src_sel_q, src_sel_d;
  logic              disp_en_q, disp_en_d;
  logic              ack_q, ack_d;
  logic              busy_q, busy_d;
  logic              load_ovl;

  seg_prescaler #(
    .PRESCALE(PRESCALE)
  ) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  // Next-state, hold counter and output decode; outputs follow the next state.
  always_comb begin
    state_d  = state_q;
    hold_d   = hold_q;
    load_ovl = 1'b0;

    case (state_q)
      S_OFF: begin
        if (ovl_req) begin
          state_d  = S_OVL;
          load_ovl = 1'b1;
        end else if (pri_valid) begin
          state_d = S_PRI;
        end else begin
          state_d = S_OFF;
        end
      end
      S_PRI: begin
        // An overlay request pre-empts the primary source.
        if (ovl_req) begin
          state_d  = S_OVL;
          load_ovl = 1'b1;
        end else if (!pri_valid) begin
          state_d = S_OFF;
        end else begin
          state_d = S_PRI;
        end
      end
      S_OVL: begin
        // A retrigger wins over an expiry landing on the same edge.
        if (ovl_req) begin
          state_d  = S_OVL;
          load_ovl = 1'b1;
        end else if (tick && (hold_q == HOLD_LAST)) begin
          state_d = pri_valid ? S_PRI : S_OFF;
        end else if (tick) begin
          state_d = S_OVL;
          hold_d  = hold_q + HOLD_W'(1);
        end else begin
          state_d = S_OVL;
        end
      end
      default: begin
        state_d = S_OFF;
      end
    endcase

    if (load_ovl) begin
      hold_d = '0;
    end else begin
      hold_d = hold_d;
    end

    // Overlay word is captured once; primary word is tracked every cycle
    // while the primary source is (or is becoming) the owner.
    if (load_ovl) begin
      bcd_d = fmt_word(ovl_bcd);
    end else if ((state_d == S_PRI) || (state_q == S_PRI)) begin
      bcd_d = fmt_word(pri_bcd);
    end else begin
      bcd_d = bcd_q;
    end

    case (state_d)
      S_PRI:   src_sel_d = SRC_PRI;
      S_OVL:   src_sel_d = SRC_OVL;
      S_OFF:   src_sel_d = SRC_NONE;
      default: src_sel_d = SRC_NONE;
    endcase

    disp_en_d = !blank && (src_sel_d != SRC_NONE);
    ack_d     = load_ovl;
    busy_d    = (state_d == S_OVL);
  end

  // State, hold counter and registered outputs with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_OFF;
      hold_q    <= '0;
      bcd_q     <= 16'h0000;
      src_sel_q <= SRC_NONE;
      disp_en_q <= 1'b0;
      ack_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      hold_q    <= hold_d;
      bcd_q     <= bcd_d;
      src_sel_q <= src_sel_d;
      disp_en_q <= disp_en_d;
      ack_q     <= ack_d;
      busy_q    <= busy_d;
    end
  end

  assign ovl_ack      = ack_q;
  assign ovl_busy     = busy_q;
  assign refresh_tick = tick;
  assign disp_en      = disp_en_q;
  assign bcd_out      = bcd_q;
  assign src_sel      = src_sel_q;

endmodule

// File: tb/tb_seg_display_ctrl.sv
// Directed bench for seg_display_ctrl with PRESCALE=4, HOLD_TICKS=3.
// A vector table covers reset, primary display, overlay expiry, retrigger
// on the expiry edge and blanking; short hand sequences cover reset
// during an overlay and leading-zero blanking (SEG_LZB_EN).
module tb_seg_display_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] pri_bcd = 16'h0000;
  logic        pri_valid = 1'b0;
  logic [15:0] ovl_bcd = 16'h0000;
  logic        ovl_req = 1'b0;
  logic        blank = 1'b0;
  logic        ovl_ack, ovl_busy, refresh_tick, disp_en;
  logic [15:0] bcd_out;
  logic [1:0]  src_sel;

  int n_cmp = 0;
  int n_bad = 0;
  int ph    = 0;

  typedef struct {
    logic        rst;
    logic        pv;
    logic [15:0] pbcd;
    logic        oreq;
    logic [15:0] obcd;
    logic        blank;
    logic [1:0]  src;
    logic        en;
    logic [15:0] bcd;
    logic        ack;
    logic        busy;
  } vec_t;

  vec_t tbl[$];

  seg_display_ctrl #(
    .PRESCALE   (4),
    .HOLD_TICKS (3)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .pri_bcd      (pri_bcd),
    .pri_valid    (pri_valid),
    .ovl_bcd      (ovl_bcd),
    .ovl_req      (ovl_req),
    .ovl_ack      (ovl_ack),
    .ovl_busy     (ovl_busy),
    .blank        (blank),
    .refresh_tick (refresh_tick),
    .disp_en      (disp_en),
    .bcd_out      (bcd_out),
    .src_sel      (src_sel)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic pv, input logic [15:0] pb,
                     input logic oq, input logic [15:0] ob, input logic bl,
                     input logic [1:0] src, input logic en, input logic [15:0] bcd,
                     input logic ack, input logic busy);
    vec_t v;
    v.rst = r;   v.pv = pv;   v.pbcd = pb;  v.oreq = oq; v.obcd = ob;
    v.blank = bl; v.src = src; v.en = en;   v.bcd = bcd; v.ack = ack;
    v.busy = busy;
    tbl.push_back(v);
  endtask

  // Drive one cycle of inputs, clock it, then check every output.
  task automatic apply(input vec_t v, input string tag);
    logic exp_tick;
    rst = v.rst; pri_valid = v.pv; pri_bcd = v.pbcd;
    ovl_req = v.oreq; ovl_bcd = v.obcd; blank = v.blank;
    @(posedge clk);
    #1;
    if (v.rst) ph = 0;
    else       ph = (ph + 1) % 4;
    exp_tick = !v.rst && (ph == 3);
    chk({tag, ".src_sel"},      {14'd0, src_sel},      {14'd0, v.src});
    chk({tag, ".disp_en"},      {15'd0, disp_en},      {15'd0, v.en});
    chk({tag, ".bcd_out"},      bcd_out,               v.bcd);
    chk({tag, ".ovl_ack"},      {15'd0, ovl_ack},      {15'd0, v.ack});
    chk({tag, ".ovl_busy"},     {15'd0, ovl_busy},     {15'd0, v.busy});
    chk({tag, ".refresh_tick"}, {15'd0, refresh_tick}, {15'd0, exp_tick});
  endtask

  initial begin
    logic [15:0] exp_50, exp_00, exp_07;
    vec_t v;
`ifdef SEG_LZB_EN
    exp_50 = 16'hFF50; exp_00 = 16'hFFF0; exp_07 = 16'hFFF7;
`else
    exp_50 = 16'h0050; exp_00 = 16'h0000; exp_07 = 16'h0007;
`endif

    // Rows indexed by clock edge; refresh ticks appear after edges 4,8,12,...
    // and are acted on by the FSM at edges 5,9,13,...
    for (int i = 0; i < 2; i++)  add(1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 2'b00, 1'b0, 16'h0000, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++)  add(1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 2'b00, 1'b0, 16'h0000, 1'b0, 1'b0);
    add(1'b0, 1'b1, 16'h1234, 1'b0, 16'h0000, 1'b0, 2'b01, 1'b1, 16'h1234, 1'b0, 1'b0);
    add(1'b0, 1'b1, 16'h5678, 1'b0, 16'h0000, 1'b0, 2'b01, 1'b1, 16'h5678, 1'b0, 1'b0);
    // Overlay from primary; expires at edge 17 after the third tick.
    add(1'b0, 1'b1, 16'h5678, 1'b1, 16'hABCD, 1'b0, 2'b10, 1'b1, 16'hABCD, 1'b1, 1'b1);
    for (int i = 0; i < 9; i++)  add(1'b0, 1'b1, 16'h9999, 1'b0, 16'h0000, 1'b0, 2'b10, 1'b1, 16'hABCD, 1'b0, 1'b1);
    add(1'b0, 1'b1, 16'h9999, 1'b0, 16'h0000, 1'b0, 2'b01, 1'b1, 16'h9999, 1'b0, 1'b0);
    // Overlay again, primary drops away; expiry at edge 29 returns to off.
    add(1'b0, 1'b1, 16'h9999, 1'b1, 16'h7BEE, 1'b0, 2'b10, 1'b1, 16'h7BEE, 1'b1, 1'b1);
    for (int i = 0; i < 10; i++) add(1'b0, 1'b0, 16'h9999, 1'b0, 16'h0000, 1'b0, 2'b10, 1'b1, 16'h7BEE, 1'b0, 1'b1);
    add(1'b0, 1'b0, 16'h9999, 1'b0, 16'h0000, 1'b0, 2'b00, 1'b0, 16'h7BEE, 1'b0, 1'b0);
    // Overlay from off; retrigger exactly on the expiry edge (41).
    add(1'b0, 1'b0, 16'h0000, 1'b1, 16'h1357, 1'b0, 2'b10, 1'b1, 16'h1357, 1'b1, 1'b1);
    for (int i = 0; i < 10; i++) add(1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 2'b10, 1'b1, 16'h1357, 1'b0, 1'b1);
    add(1'b0, 1'b0, 16'h0000, 1'b1, 16'h2468, 1'b0, 2'b10, 1'b1, 16'h2468, 1'b1, 1'b1);
    add(1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 2'b10, 1'b1, 16'h2468, 1'b0, 1'b1);
    // Blanked through the restarted hold; expiry still lands on edge 53.
    for (int i = 0; i < 10; i++) add(1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 2'b10, 1'b0, 16'h2468, 1'b0, 1'b1);
    add(1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 2'b00, 1'b0, 16'h2468, 1'b0, 1'b0);
    add(1'b0, 1'b1, 16'h4444, 1'b0, 16'h0000, 1'b1, 2'b01, 1'b0, 16'h4444, 1'b0, 1'b0);
    add(1'b0, 1'b1, 16'h4444, 1'b0, 16'h0000, 1'b0, 2'b01, 1'b1, 16'h4444, 1'b0, 1'b0);

    foreach (tbl[i]) apply(tbl[i], $sformatf("row%0d", i));

    // Reset during an overlay: aborted, outputs cleared, no ack even with req high.
    add(1'b0, 1'b0, 16'h0000, 1'b1, 16'h4321, 1'b0, 2'b10, 1'b1, 16'h4321, 1'b1, 1'b1);
    apply(tbl[tbl.size()-1], "abort_enter");
    add(1'b1, 1'b0, 16'h0000, 1'b1, 16'h8888, 1'b0, 2'b00, 1'b0, 16'h0000, 1'b0, 1'b0);
    apply(tbl[tbl.size()-1], "abort_rst");
    for (int i = 0; i < 2; i++) begin
      add(1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 2'b00, 1'b0, 16'h0000, 1'b0, 1'b0);
      apply(tbl[tbl.size()-1], $sformatf("abort_idle%0d", i));
    end

    // Leading-zero blanking on the primary path.
    add(1'b0, 1'b1, 16'h0050, 1'b0, 16'h0000, 1'b0, 2'b01, 1'b1, exp_50, 1'b0, 1'b0);
    apply(tbl[tbl.size()-1], "lzb_0050");
    add(1'b0, 1'b1, 16'h0000, 1'b0, 16'h0000, 1'b0, 2'b01, 1'b1, exp_00, 1'b0, 1'b0);
    apply(tbl[tbl.size()-1], "lzb_0000");
    add(1'b0, 1'b1, 16'h0007, 1'b0, 16'h0000, 1'b0, 2'b01, 1'b1, exp_07, 1'b0, 1'b0);
    apply(tbl[tbl.size()-1], "lzb_0007");
    add(1'b0, 1'b1, 16'h1000, 1'b0, 16'h0000, 1'b0, 2'b01, 1'b1, 16'h1000, 1'b0, 1'b0);
    apply(tbl[tbl.size()-1], "lzb_1000");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
